// File: rtl/mod_counter.sv
// Up/down modulo counter with preload, writable modulus, wrap or one-shot mode,
// registered terminal tick and sticky done flag. Optional comparator: MOD_COUNTER_CMP_EN.
module mod_counter #(
  parameter int WIDTH   = 8,
  parameter int DEF_MAX = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srst,
  input  logic             i_cnt_en,
  input  logic             i_dir,
  input  logic             i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_max_wr,
  input  logic [WIDTH-1:0] i_max_val,
`ifdef MOD_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] i_cmp_val,
  output logic             o_cmp,
`endif
  output logic [WIDTH-1:0] o_data,
  output logic             o_tick,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] DefMax = WIDTH'(DEF_MAX);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             step_en;
  logic             terminal;

  // A completed one-shot swallows enables until it is cleared.
  assign step_en  = i_cnt_en & ~done_q;
  assign terminal = step_en & (i_dir ? (count_q >= max_q) : (count_q == '0));

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = done_q & i_mode;
    max_d   = i_max_wr ? i_max_val : max_q;

    if (i_srst) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (i_load) begin
      count_d = (i_load_val > max_q) ? max_q : i_load_val;
      done_d  = 1'b0;
    end else if (step_en) begin
      if (terminal) begin
        tick_d = 1'b1;
        if (i_mode) begin
          done_d = 1'b1;
        end else begin
          count_d = i_dir ? '0 : max_q;
        end
      end else begin
        count_d = i_dir ? (count_q + One) : (count_q - One);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
      max_q   <= DefMax;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

`ifdef MOD_COUNTER_CMP_EN
  logic cmp_q, cmp_d;

  always_comb begin
    cmp_d = 1'b0;
    if (!i_srst) begin
      cmp_d = (count_q == i_cmp_val);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmp_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
    end
  end

  assign o_cmp = cmp_q;
`endif

  assign o_data = count_q;
  assign o_tick = tick_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed table-driven bench for mod_counter (WIDTH=4, DEF_MAX=7) plus hand-written
// async-reset and comparator sequences.
module tb_mod_counter;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_srst = 1'b0;
  logic       i_cnt_en = 1'b0;
  logic       i_dir = 1'b1;
  logic       i_mode = 1'b0;
  logic       i_load = 1'b0;
  logic [3:0] i_load_val = '0;
  logic       i_max_wr = 1'b0;
  logic [3:0] i_max_val = '0;
  logic [3:0] i_cmp_val = 4'd5;
  logic [3:0] o_data;
  logic       o_tick;
  logic       o_done;
`ifdef MOD_COUNTER_CMP_EN
  logic       o_cmp;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mod_counter #(.WIDTH(4), .DEF_MAX(7)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_srst    (i_srst),
    .i_cnt_en  (i_cnt_en),
    .i_dir     (i_dir),
    .i_mode    (i_mode),
    .i_load    (i_load),
    .i_load_val(i_load_val),
    .i_max_wr  (i_max_wr),
    .i_max_val (i_max_val),
`ifdef MOD_COUNTER_CMP_EN
    .i_cmp_val (i_cmp_val),
    .o_cmp     (o_cmp),
`endif
    .o_data    (o_data),
    .o_tick    (o_tick),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       srst, en, dir, mode, load;
    logic [3:0] lval;
    logic       mw;
    logic [3:0] mval;
    logic [3:0] e_data;
    logic       e_tick, e_done;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  task automatic addv(input logic srst, en, dir, mode, load, input logic [3:0] lval,
                      input logic mw, input logic [3:0] mval,
                      input logic [3:0] e_data, input logic e_tick, e_done);
    vecs[n_vec] = '{srst, en, dir, mode, load, lval, mw, mval, e_data, e_tick, e_done};
    n_vec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_srst = 0; i_cnt_en = 0; i_load = 0; i_max_wr = 0;
  endtask

  initial begin
    // wrap up-count, MAX=7 from reset
    for (int k = 1; k <= 17; k++)
      addv(0, 1, 1, 0, 0, 0, 0, 0, 4'(k % 8), (k % 8) == 0, 0);
    // down wrap, MAX=5, load 2
    addv(0, 0, 1, 0, 0, 0, 1, 5, 1, 0, 0);
    addv(0, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 4, 0, 0);
    // one-shot up, MAX=3 (written alongside srst)
    addv(1, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 2, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 3, 1, 1);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 1);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 3, 0, 1);
    addv(0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0);
    addv(0, 1, 1, 1, 0, 0, 0, 0, 2, 0, 0);
    // MAX rewritten below count, load clamp
    addv(0, 0, 1, 0, 0, 0, 1, 15, 2, 0, 0);
    addv(0, 0, 1, 0, 1, 10, 0, 0, 10, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 1, 4, 10, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 0, 1, 0, 1, 9, 0, 0, 4, 0, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    addv(0, 0, 1, 0, 1, 9, 0, 0, 4, 0, 0);
    // srst beats load and a terminal step; MAX stays 4
    addv(1, 1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 1, 9, 0, 0, 4, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    // MAX=0: every enabled step terminal
    addv(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    #12;
    check("reset_data", o_data, 0);
    check("reset_tick", o_tick, 0);
    check("reset_done", o_done, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      @(negedge i_clk);
      i_srst = vecs[i].srst; i_cnt_en = vecs[i].en; i_dir = vecs[i].dir;
      i_mode = vecs[i].mode; i_load = vecs[i].load; i_load_val = vecs[i].lval;
      i_max_wr = vecs[i].mw; i_max_val = vecs[i].mval;
      @(posedge i_clk); #1;
      check($sformatf("vec%0d_data", i), o_data, vecs[i].e_data);
      check($sformatf("vec%0d_tick", i), o_tick, vecs[i].e_tick);
      check($sformatf("vec%0d_done", i), o_done, vecs[i].e_done);
    end

    // async reset mid-cycle with tick and done both high; MAX must return to 7
    @(negedge i_clk); idle_inputs(); i_max_wr = 1; i_max_val = 12;
    @(negedge i_clk); idle_inputs(); i_load = 1; i_load_val = 11; i_mode = 1; i_dir = 1;
    @(negedge i_clk); idle_inputs(); i_cnt_en = 1;
    @(posedge i_clk); @(posedge i_clk); #1;
    check("pre_rst_data", o_data, 12);
    check("pre_rst_tick", o_tick, 1);
    check("pre_rst_done", o_done, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_data", o_data, 0);
    check("arst_tick", o_tick, 0);
    check("arst_done", o_done, 0);
    @(negedge i_clk); i_rst_n = 1'b1; i_mode = 0; i_cnt_en = 1;
    repeat (7) @(posedge i_clk);
    #1 check("post_rst_data7", o_data, 7);
    check("post_rst_tick7", o_tick, 0);
    @(posedge i_clk); #1;
    check("post_rst_wrap_data", o_data, 0);
    check("post_rst_wrap_tick", o_tick, 1);

`ifdef MOD_COUNTER_CMP_EN
    @(negedge i_clk); idle_inputs(); i_srst = 1;
    @(posedge i_clk); #1 check("cmp_srst", o_cmp, 0);
    @(negedge i_clk); idle_inputs(); i_cnt_en = 1; i_dir = 1; i_cmp_val = 5;
    for (int k = 1; k <= 9; k++) begin
      @(posedge i_clk); #1;
      check($sformatf("cmp_step%0d", k), o_cmp, (k - 1) == 5);
    end
`endif

    @(negedge i_clk); idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter, load and modulus width in bits (2..32).
REQ-002 SHALL have parameter DEF_MAX, default 255: modulus register value after async reset, less than 2^WIDTH.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_srst, input, 1 bit: synchronous clear.
REQ-006 SHALL have port i_cnt_en, input, 1 bit: count enable, one step per enabled cycle.
REQ-007 SHALL have port i_dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 SHALL have port i_mode, input, 1 bit: 0 = wrap, 1 = one-shot.
REQ-009 SHALL have port i_load, input, 1 bit, and port i_load_val, input, WIDTH bits: synchronous counter preload.
REQ-010 SHALL have port i_max_wr, input, 1 bit, and port i_max_val, input, WIDTH bits: modulus register write.
REQ-011 SHALL have port o_data, output, WIDTH bits: current count.
REQ-012 SHALL have port o_tick, output, 1 bit: registered terminal-count pulse.
REQ-013 SHALL have port o_done, output, 1 bit: one-shot completion flag, sticky.

Function
REQ-014 SHALL hold the modulus in an internal register MAX; i_max_wr loads i_max_val and the new value is used from the next cycle.
REQ-015 SHALL apply per-edge priority i_srst > i_load > counting; i_max_wr is independent of this priority.
REQ-016 On i_load, count SHALL become min(i_load_val, MAX), o_done SHALL clear, and no tick is generated.
REQ-017 Up terminal SHALL be count >= MAX with i_cnt_en=1; the step SHALL set count to 0 in wrap mode and hold count in one-shot mode.
REQ-018 Down terminal SHALL be count == 0 with i_cnt_en=1; the step SHALL set count to MAX in wrap mode and hold count in one-shot mode.
REQ-019 A non-terminal enabled step SHALL add 1 (up) or subtract 1 (down) modulo 2^WIDTH.
REQ-020 o_tick SHALL be 1 for exactly the one cycle after a terminal step edge and 0 otherwise; there is no combinational path from inputs to o_tick.
REQ-021 In one-shot mode a terminal step SHALL set o_done=1 and produce one o_tick; while o_done=1, i_cnt_en SHALL be ignored.
REQ-022 o_done SHALL clear on i_srst, on i_load, or on any cycle with i_mode=0.
REQ-023 If MAX is rewritten below the current count, up-counting SHALL treat the next enabled cycle as terminal; down-counting SHALL be unaffected.
REQ-024 With MAX=0, every enabled cycle SHALL be terminal in both directions, and count SHALL stay at 0.
REQ-025 i_dir and i_mode changes SHALL take effect on the same edge they are sampled.

Reset
REQ-026 On i_rst_n=0, immediately and regardless of i_clk: count=0, MAX=DEF_MAX, o_tick=0, o_done=0, o_cmp=0.
REQ-027 i_srst SHALL clear count, o_tick and o_done on the next edge and SHALL leave MAX unchanged.

Configuration
REQ-028 Macro MOD_COUNTER_CMP_EN defined: SHALL add input i_cmp_val (WIDTH bits) and output o_cmp (1 bit); o_cmp SHALL be registered (o_data == i_cmp_val), i.e. 1 the cycle after a match, and cleared by i_srst.
REQ-029 Macro MOD_COUNTER_CMP_EN undefined: i_cmp_val, o_cmp and the comparator logic SHALL be absent.

Verification
REQ-030 WIDTH=4, MAX=7, up, wrap, i_cnt_en held -> o_data 0..7,0,...; o_tick high one cycle after each 7->0 edge, period 8.
REQ-031 Down, wrap, MAX=5, load 2 -> o_data 2,1,0,5,4; o_tick pulses once after the 0->5 edge.
REQ-032 One-shot, up, MAX=3 from 0 -> o_data 0,1,2,3,3,...; o_done=1 and a single o_tick; a following i_load of 1 clears o_done and counting resumes.
REQ-033 Count=10, write MAX=4, up enabled -> next edge o_data=0 with o_tick; load 9 with MAX=4 -> o_data=4.
REQ-034 i_srst, i_load and a terminal step in the same cycle -> o_data=0, o_tick stays 0, MAX unchanged; i_rst_n pulsed mid-count -> outputs zero immediately, MAX=DEF_MAX.
REQ-035 CMP_EN build, i_cmp_val=5, up from 0 -> o_cmp high only on the cycle after o_data=5.
